// File: rtl/counter_pkg.sv
// Shared definitions for the multi-code counter: output-code selectors and
// the binary-to-Gray conversion used on the registered output path.
package counter_pkg;

    localparam logic [1:0] MODE_BIN     = 2'b00;
    localparam logic [1:0] MODE_GRAY    = 2'b01;
    localparam logic [1:0] MODE_JOHNSON = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    // Works for any width up to 32; callers size-cast the result to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/counter_johnson.sv
// Johnson (twisted-ring) register with 2*WIDTH states, synchronous clear and
// terminal-state decode for the current count direction.
module counter_johnson #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] TERM_UP   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] TERM_DOWN = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        // NOTE: default first so every path assigns q_d and no latch is inferred.
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (enable) begin
            q_d = up ? {q_q[WIDTH-2:0], ~q_q[WIDTH-1]}
                     : {~q_q[0], q_q[WIDTH-1:1]};
        end
    end

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q        = q_q;
    assign q_next   = q_d;
    assign terminal = up ? (q_q == TERM_UP) : (q_q == TERM_DOWN);

endmodule

// File: rtl/counter_multi.sv
// Up/down counter with runtime-selectable binary, Gray or Johnson output code,
// parallel load, wrap/saturate policy and a terminal-count flag.
module counter_multi #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH-1,
    parameter bit WRAP      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             tc
);

    import counter_pkg::*;

    localparam logic [WIDTH-1:0] MAX_IDX = WIDTH'(MAX_COUNT);

    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] count_q, count_d;

    logic             mode_change;
    logic             is_johnson;
    logic             j_en;
    logic             j_terminal;
    logic             bg_terminal;
    logic             load_eff;
    logic [WIDTH-1:0] j_q, j_next;

    assign mode_change = (mode != mode_q);
    assign is_johnson  = (mode_q == MODE_JOHNSON);
    assign j_en        = enable & is_johnson;
    // Load never reaches the Johnson register, so it cannot suppress a Johnson step.
    assign load_eff    = load & ~is_johnson;
    assign bg_terminal = up ? (idx_q == MAX_IDX) : (idx_q == '0);

    counter_johnson #(.WIDTH(WIDTH)) u_johnson (
        .clk      (clk),
        .reset    (reset),
        .clear    (mode_change),
        .enable   (j_en),
        .up       (up),
        .q        (j_q),
        .q_next   (j_next),
        .terminal (j_terminal)
    );

    always_comb begin
        mode_d = mode_q;
        idx_d  = idx_q;
        if (mode_change) begin
            mode_d = mode;
            idx_d  = '0;
        end else if (!is_johnson) begin
            if (load) begin
                idx_d = (load_val > MAX_IDX) ? MAX_IDX : load_val;
            end else if (enable) begin
                if (up) begin
                    idx_d = (idx_q == MAX_IDX) ? (WRAP ? '0 : idx_q) : idx_q + WIDTH'(1);
                end else begin
                    idx_d = (idx_q == '0) ? (WRAP ? MAX_IDX : idx_q) : idx_q - WIDTH'(1);
                end
            end
        end
    end

    // Encode the next state here so count_out comes straight off a flop.
    always_comb begin
        count_d = '0;
        if (!mode_change) begin
            case (mode_q)
                MODE_GRAY:          count_d = WIDTH'(bin2gray(32'(idx_d)));
                MODE_JOHNSON:       count_d = j_en ? j_next : j_q;
                MODE_BIN, MODE_RSVD: count_d = idx_d;
                default:            count_d = idx_d;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= MODE_BIN;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    assign count_out = count_q;
    assign tc = ~reset & ~mode_change & enable & ~load_eff
              & (is_johnson ? j_terminal : bg_terminal);

endmodule
